// File: rtl/fp_cmp_arbiter.sv
// Round-robin share of one fixed-latency FP compare unit; accept->resp_valid takes LATENCY+2 cycles.
// pause withholds grants only, responses cannot be stalled; FP_CMP_ARB_CHECK_EN adds sticky cmp_err.
module fp_cmp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pause,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [2:0]            resp_result,
  output logic                  cmp_go,
  output logic [31:0]           cmp_a,
  output logic [31:0]           cmp_b,
  input  logic                  cmp_done,
  input  logic [2:0]            cmp_result
`ifdef FP_CMP_ARB_CHECK_EN
  ,
  output logic                  cmp_err
`endif
);

  localparam int SW = TAG_W + 1;

  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   ptr_next;
  logic [SW-1:0]      scan;
  logic               grant_any;
  logic [TAG_W-1:0]   grant_idx;
  logic               accept;
  logic [TAG_W-1:0]   go_tag;

  logic               pipe_vld [LATENCY];
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic               head_vld;
  logic [TAG_W-1:0]   head_tag;
  logic [NUM_REQ-1:0] head_oh;

  // Rotating priority scan starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + SW'(k);
      if (scan >= SW'(NUM_REQ)) begin
        scan = scan - SW'(NUM_REQ);
      end
      if (!grant_any && req_valid[scan[TAG_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[TAG_W-1:0];
      end
    end
  end

  assign accept   = grant_any & ~pause & ~reset;
  assign ptr_next = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      cmp_go <= 1'b0;
      go_tag <= '0;
      cmp_a  <= '0;
      cmp_b  <= '0;
    end else begin
      cmp_go <= accept;
      if (accept) begin
        ptr    <= ptr_next;
        go_tag <= grant_idx;
        cmp_a  <= req_a[{grant_idx, 5'd0} +: 32];
        cmp_b  <= req_b[{grant_idx, 5'd0} +: 32];
      end
    end
  end

  // Owner tags ride alongside the compare unit; the head lines up with its result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_vld[s] <= 1'b0;
        pipe_tag[s] <= '0;
      end
    end else begin
      pipe_vld[0] <= cmp_go;
      pipe_tag[0] <= go_tag;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end
    end
  end

  assign head_vld = pipe_vld[LATENCY-1];
  assign head_tag = pipe_tag[LATENCY-1];

  always_comb begin
    head_oh = '0;
    if (head_vld) begin
      head_oh[head_tag] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid  <= '0;
      resp_result <= '0;
    end else begin
      resp_valid <= head_oh;
      if (head_vld) begin
        resp_result <= cmp_result;
      end
    end
  end

`ifdef FP_CMP_ARB_CHECK_EN
  localparam int MW = $clog2(LATENCY + 1);

  logic [MW-1:0] mask_cnt;
  logic          check_on;

  // The unit's trigger chain is unreset, so stale done pulses are ignored until it has drained.
  assign check_on = (mask_cnt == MW'(LATENCY));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_cnt <= '0;
      cmp_err  <= 1'b0;
    end else begin
      if (!check_on) begin
        mask_cnt <= mask_cnt + MW'(1);
      end
      if (check_on && (cmp_done != head_vld)) begin
        cmp_err <= 1'b1;
      end
    end
  end
`else
  // Routing relies on the tag pipeline alone, so cmp_done has no consumer here.
  logic unused_cmp_done;
  assign unused_cmp_done = cmp_done;
`endif

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Bench for fp_cmp_arbiter: behavioural compare-unit model plus a per-cycle schedule of expected outputs.
module tb_fp_cmp_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int MAXC = 1024;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pause = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   resp_valid;
  logic [2:0]        resp_result;
  logic              cmp_go;
  logic [31:0]       cmp_a, cmp_b;
  logic              cmp_done;
  logic [2:0]        cmp_result;
`ifdef FP_CMP_ARB_CHECK_EN
  logic              cmp_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fp_cmp_arbiter #(.NUM_REQ(NREQ), .LATENCY(LAT), .TAG_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pause       (pause),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .cmp_go      (cmp_go),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_done    (cmp_done),
    .cmp_result  (cmp_result)
`ifdef FP_CMP_ARB_CHECK_EN
    ,
    .cmp_err     (cmp_err)
`endif
  );

  // IEEE-754 single ordering for non-NaN values: {a<=b, a<b, a==b}, with +0 == -0.
  function automatic logic [2:0] fpcmp(input logic [31:0] a, input logic [31:0] b);
    logic eq, lt;
    eq = (a[30:0] == 31'd0 && b[30:0] == 31'd0) ? 1'b1 : (a == b);
    if (eq)                lt = 1'b0;
    else if (a[31] != b[31]) lt = a[31];
    else if (!a[31])       lt = (a[30:0] < b[30:0]);
    else                   lt = (a[30:0] > b[30:0]);
    return {eq | lt, lt, eq};
  endfunction

  // External compare unit: fixed latency, deliberately without reset.
  logic       u_vld [LAT] = '{default: 1'b0};
  logic [2:0] u_res [LAT] = '{default: 3'b000};
  logic       force_done = 1'b0;

  always @(posedge clock) begin
    u_vld[0] <= cmp_go;
    u_res[0] <= fpcmp(cmp_a, cmp_b);
    for (int s = 1; s < LAT; s++) begin
      u_vld[s] <= u_vld[s-1];
      u_res[s] <= u_res[s-1];
    end
  end

  assign cmp_done   = u_vld[LAT-1] | force_done;
  assign cmp_result = u_res[LAT-1];

  // Expected-output schedule indexed by cycle number.
  int          cyc = 0;
  int          ptr_m = 0;
  int          since_rel = 0;
  logic        exp_go   [MAXC];
  logic [31:0] exp_ca   [MAXC];
  logic [31:0] exp_cb   [MAXC];
  int          exp_rtag [MAXC];
  logic [2:0]  exp_rres [MAXC];
  logic [31:0] last_ca = '0, last_cb = '0;
  logic [2:0]  last_res = '0;
  logic        exp_err = 1'b0, err_pending = 1'b0;
  int          grant_log [$];
  int          ord2 [5] = '{0, 1, 2, 3, 0};
  int          ord3 [6] = '{3, 1, 3, 1, 3, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic run_cycle();
    logic [NREQ-1:0] exp_rdy, exp_rv;
    int g;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!reset && !pause) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));

    if (reset) begin
      ptr_m = 0; since_rel = 0; exp_err = 1'b0; err_pending = 1'b0;
      last_ca = '0; last_cb = '0; last_res = '0;
      for (int c = cyc; c < MAXC; c++) begin
        exp_go[c] = 1'b0;
        exp_rtag[c] = -1;
      end
    end else begin
      if (exp_go[cyc]) begin
        last_ca = exp_ca[cyc];
        last_cb = exp_cb[cyc];
      end
      if (exp_rtag[cyc] >= 0) last_res = exp_rres[cyc];
    end
    exp_rv = '0;
    if (exp_rtag[cyc] >= 0) exp_rv[exp_rtag[cyc]] = 1'b1;

    chk("cmp_go",      64'(cmp_go),      64'(exp_go[cyc]));
    chk("cmp_a",       64'(cmp_a),       64'(last_ca));
    chk("cmp_b",       64'(cmp_b),       64'(last_cb));
    chk("resp_valid",  64'(resp_valid),  64'(exp_rv));
    chk("resp_result", 64'(resp_result), 64'(last_res));
`ifdef FP_CMP_ARB_CHECK_EN
    exp_err = exp_err | err_pending;
    chk("cmp_err", 64'(cmp_err), 64'(exp_err));
    if (!reset && since_rel >= LAT && (cmp_done !== (exp_rtag[cyc+1] >= 0))) err_pending = 1'b1;
`endif

    if (g >= 0) begin
      ptr_m = (g + 1) % NREQ;
      grant_log.push_back(g);
      exp_go[cyc+1]         = 1'b1;
      exp_ca[cyc+1]         = req_a[32*g +: 32];
      exp_cb[cyc+1]         = req_b[32*g +: 32];
      exp_rtag[cyc+LAT+2]   = g;
      exp_rres[cyc+LAT+2]   = fpcmp(req_a[32*g +: 32], req_b[32*g +: 32]);
    end
    if (!reset) since_rel++;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    if (v[30:23] == 8'hFF) v[30] = 1'b0;
    return v;
  endfunction

  task automatic rand_ops();
    logic [31:0] a, b;
    for (int i = 0; i < NREQ; i++) begin
      a = rand_fp();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = {~a[31], a[30:0]};
        2:       begin a = {a[31], 31'd0}; b = {~a[31], 31'd0}; end
        default: b = rand_fp();
      endcase
      set_ops(i, a, b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int c = 0; c < MAXC; c++) begin
      exp_go[c] = 1'b0;
      exp_rtag[c] = -1;
      exp_rres[c] = '0;
    end

    // Reset state.
    run_cycle();
    run_cycle();
    reset = 1'b0;

    // All requesters valid from reset: strict rotation.
    grant_log.delete();
    req_valid = 4'hF;
    repeat (5) begin
      rand_ops();
      run_cycle();
    end
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(grant_log[i]), 64'(ord2[i]));
    req_valid = '0;
    repeat (LAT + 3) run_cycle();

    // Single request 1.0 vs 2.0 from requester 2.
    set_ops(2, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b0100;
    run_cycle();
    req_valid = '0;
    repeat (4) run_cycle();
    #1;
    chk("single_resp_valid",  64'(resp_valid),  64'(4'b0100));
    chk("single_resp_result", 64'(resp_result), 64'(3'b110));
    run_cycle();

    // Fairness between requesters 1 and 3 with pointer parked at 2.
    req_valid = 4'b0010;
    run_cycle();
    set_ops(1, 32'h4049_0FDB, 32'h4049_0FDB);
    set_ops(3, 32'hC120_0000, 32'hC120_0000);
    grant_log.delete();
    req_valid = 4'b1010;
    repeat (6) run_cycle();
    for (int i = 0; i < 6; i++) chk("fair_order", 64'(grant_log[i]), 64'(ord3[i]));
    req_valid = '0;
    repeat (LAT + 3) run_cycle();
    chk("fair_hold_result", 64'(resp_result), 64'(3'b101));

    // Pause with everyone valid: grants stop, in-flight responses continue.
    rand_ops();
    req_valid = 4'hF;
    repeat (2) run_cycle();
    n0 = grant_log.size();
    pause = 1'b1;
    repeat (3) run_cycle();
    pause = 1'b0;
    repeat (3) run_cycle();
    chk("pause_resume_ptr", 64'(grant_log[n0]), 64'((grant_log[n0-1] + 1) % NREQ));
    req_valid = '0;
    repeat (LAT + 3) run_cycle();

    // Lone requester granted every cycle.
    n0 = grant_log.size();
    req_valid = 4'b0001;
    repeat (5) begin
      rand_ops();
      run_cycle();
    end
    chk("single_every_cycle", 64'(grant_log.size() - n0), 64'd5);
    req_valid = '0;
    repeat (LAT + 3) run_cycle();

    // Reset with two compares in flight; stale done pulses follow release.
    rand_ops();
    req_valid = 4'b0011;
    repeat (2) run_cycle();
    req_valid = '0;
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    repeat (LAT + 4) run_cycle();
    chk("reset_drop_resp", 64'(resp_valid), 64'd0);
`ifdef FP_CMP_ARB_CHECK_EN
    chk("reset_err_clear", 64'(cmp_err), 64'd0);

    // Spurious done with an empty pipeline sets the sticky error.
    force_done = 1'b1;
    run_cycle();
    force_done = 1'b0;
    repeat (3) run_cycle();
    chk("err_sticky", 64'(cmp_err), 64'd1);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    run_cycle();
    chk("err_cleared", 64'(cmp_err), 64'd0);
`endif

    // Randomised traffic with occasional pause and one reset.
    for (int i = 0; i < 300; i++) begin
      req_valid = NREQ'($urandom);
      pause = ($urandom_range(0, 7) == 0);
      reset = (i == 150);
      rand_ops();
      run_cycle();
    end
    reset = 1'b0;
    pause = 1'b0;
    req_valid = '0;
    repeat (LAT + 3) run_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
